// File: rtl/imm_extend_buffer.sv
// Immediate extender with a 2-entry skid FIFO: the extension is computed at the input
// and only the extended result is buffered.
module imm_extend_buffer #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16,
  parameter int SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm_in,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] imm_out
);

  generate
    if (IN_W < 1 || SHIFT < 0 || OUT_W < IN_W + SHIFT) begin : g_bad_params
      $error("imm_extend_buffer: need IN_W >= 1 and OUT_W >= IN_W + SHIFT");
    end
  endgenerate

  localparam logic [1:0] MODE_ZERO   = 2'b00;
  localparam logic [1:0] MODE_SIGN   = 2'b01;
  localparam logic [1:0] MODE_BRANCH = 2'b10;
  localparam logic [1:0] MODE_UPPER  = 2'b11;

  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_branch;
  logic [OUT_W-1:0] w_upper;
  logic [OUT_W-1:0] w_ext;

  assign w_zext   = OUT_W'(imm_in);
  assign w_sext   = OUT_W'($signed(imm_in));
  assign w_branch = w_sext << SHIFT;
  assign w_upper  = w_zext << (OUT_W - IN_W);

  always_comb begin
    w_ext = w_zext;
    case (mode)
      MODE_ZERO:   w_ext = w_zext;
      MODE_SIGN:   w_ext = w_sext;
      MODE_BRANCH: w_ext = w_branch;
      MODE_UPPER:  w_ext = w_upper;
      default:     w_ext = w_zext;
    endcase
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready depends only on registered occupancy, never on out_ready.
  logic [1:0]       r_count;
  logic [OUT_W-1:0] r_head;
  logic [OUT_W-1:0] r_tail;
  logic             w_push;
  logic             w_pop;

  assign in_ready  = (r_count < 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign imm_out   = r_head;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_push) begin
            r_head  <= w_ext;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          case ({w_push, w_pop})
            2'b11: r_head <= w_ext;
            2'b10: begin
              r_tail  <= w_ext;
              r_count <= 2'd2;
            end
            2'b01: begin
              // Clear the head so imm_out reads 0 whenever nothing is valid.
              r_head  <= '0;
              r_count <= 2'd0;
            end
            default: r_count <= 2'd1;
          endcase
        end
        2'd2: begin
          if (w_pop) begin
            r_head  <= r_tail;
            r_tail  <= '0;
            r_count <= 2'd1;
          end
        end
        default: begin
          r_count <= 2'd0;
          r_head  <= '0;
          r_tail  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_buffer.sv
// Bench for imm_extend_buffer: directed cases plus random traffic, checked by a
// scoreboard queue fed from an arithmetic reference model.
module tb_imm_extend_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  imm_in;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] imm_out;

  logic        p_in_valid;
  logic        p_in_ready;
  logic [5:0]  p_imm_in;
  logic [1:0]  p_mode;
  logic        p_out_valid;
  logic        p_out_ready;
  logic [15:0] p_imm_out;

  imm_extend_buffer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .imm_in(imm_in), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .imm_out(imm_out)
  );

  imm_extend_buffer #(.IN_W(6), .OUT_W(16), .SHIFT(2)) dut_p (
    .clk(clk), .rst(rst),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .imm_in(p_imm_in), .mode(p_mode),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .imm_out(p_imm_out)
  );

  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_pops   = 0;
  logic mon_accept;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: treat the field as an integer, apply the mode arithmetically, wrap to 16 bits.
  function automatic logic [15:0] ref_ext(input int imm, input int md, input int in_w,
                                          input int out_w, input int sh);
    longint v;
    longint m;
    v = imm;
    m = longint'(1) << out_w;
    if ((md == 1 || md == 2) && imm >= (1 << (in_w - 1))) v = imm - (longint'(1) << in_w);
    if (md == 2) v = v * (longint'(1) << sh);
    if (md == 3) v = v * (longint'(1) << (out_w - in_w));
    v = v % m;
    if (v < 0) v = v + m;
    return 16'(v);
  endfunction

  // Monitor: samples mid-cycle what the next rising edge will transfer.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      mon_accept = in_valid && (exp_q.size() < 2);
      check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
      check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      if (out_valid && exp_q.size() > 0) begin
        check("imm_out", 32'(imm_out), 32'(exp_q[0]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_pops++;
        end
      end
      if (mon_accept) exp_q.push_back(ref_ext(int'(imm_in), int'(mode), 4, 16, 1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] imm, input logic [1:0] md,
                       input logic ordy);
    in_valid  = v;
    imm_in    = imm;
    mode      = md;
    out_ready = ordy;
  endtask

  logic [3:0]  t_imm[5];
  logic [1:0]  t_mode[5];
  logic [15:0] t_exp[5];

  initial begin
    t_imm  = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0111};
    t_mode = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
    t_exp  = '{16'h000A, 16'hFFFA, 16'hFFF4, 16'hA000, 16'h0007};

    rst = 1'b1;
    drive(1'b0, 4'h0, 2'b00, 1'b0);
    p_in_valid = 1'b0; p_imm_in = '0; p_mode = 2'b00; p_out_ready = 1'b0;
    #12;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset imm_out", 32'(imm_out), 32'd0);

    // Push on the very first edge after reset release, then walk all modes.
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, t_imm[i], t_mode[i], 1'b1);
      step();
      check("mode_tbl out_valid", 32'(out_valid), 32'd1);
      check("mode_tbl imm_out", 32'(imm_out), 32'(t_exp[i]));
    end
    drive(1'b0, 4'h0, 2'b00, 1'b1);
    step();
    step();
    check("drain empty", 32'(out_valid), 32'd0);

    // Backpressure: three offers, two accepted, head held.
    drive(1'b1, 4'h3, 2'b00, 1'b0);
    step();
    check("bp in_ready after 1", 32'(in_ready), 32'd1);
    check("bp head after 1", 32'(imm_out), 32'h0003);
    drive(1'b1, 4'h9, 2'b01, 1'b0);
    step();
    check("bp in_ready after 2", 32'(in_ready), 32'd0);
    drive(1'b1, 4'h5, 2'b11, 1'b0);
    step();
    check("bp in_ready after 3", 32'(in_ready), 32'd0);
    check("bp head stable", 32'(imm_out), 32'h0003);
    step();
    check("bp head still stable", 32'(imm_out), 32'h0003);

    // Full with pop: no push this edge, ready again right after.
    drive(1'b1, 4'hC, 2'b10, 1'b1);
    step();
    check("fwp in_ready", 32'(in_ready), 32'd1);
    check("fwp head", 32'(imm_out), 32'hFFF9);
    step();
    check("fwp new head", 32'(imm_out), 32'hFFF8);
    drive(1'b0, 4'h0, 2'b00, 1'b1);
    step();
    step();
    check("fwp drained", 32'(out_valid), 32'd0);

    // Streaming: one result per cycle, 1-cycle latency.
    for (int i = 0; i < 8; i++) begin
      logic [3:0] v;
      logic [1:0] md;
      v  = 4'($urandom_range(0, 15));
      md = 2'($urandom_range(0, 3));
      drive(1'b1, v, md, 1'b1);
      step();
      check("stream in_ready", 32'(in_ready), 32'd1);
      check("stream out_valid", 32'(out_valid), 32'd1);
      check("stream imm_out", 32'(imm_out), 32'(ref_ext(int'(v), int'(md), 4, 16, 1)));
    end
    drive(1'b0, 4'h0, 2'b00, 1'b1);
    step();

    // Reset with two entries buffered.
    drive(1'b1, 4'h2, 2'b00, 1'b0);
    step();
    drive(1'b1, 4'h4, 2'b00, 1'b0);
    step();
    drive(1'b0, 4'h0, 2'b00, 1'b0);
    check("pre-reset full", 32'(in_ready), 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid rst out_valid", 32'(out_valid), 32'd0);
    check("mid rst imm_out", 32'(imm_out), 32'd0);
    check("mid rst in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_pops = 0;
    drive(1'b1, 4'hF, 2'b01, 1'b1);
    step();
    check("post rst out_valid", 32'(out_valid), 32'd1);
    check("post rst imm_out", 32'(imm_out), 32'hFFFF);
    drive(1'b0, 4'h0, 2'b00, 1'b1);
    repeat (4) step();
    check("post rst single output", 32'(n_pops), 32'd1);
    check("post rst empty", 32'(out_valid), 32'd0);

    // Non-default parameters.
    p_out_ready = 1'b1;
    p_in_valid  = 1'b1;
    p_imm_in    = 6'b100000;
    p_mode      = 2'b10;
    step();
    check("param out_valid", 32'(p_out_valid), 32'd1);
    check("param branch", 32'(p_imm_out), 32'hFF80);
    for (int i = 0; i < 6; i++) begin
      p_imm_in = 6'($urandom_range(0, 63));
      p_mode   = 2'($urandom_range(0, 3));
      step();
      check("param stream", 32'(p_imm_out),
            32'(ref_ext(int'(p_imm_in), int'(p_mode), 6, 16, 2)));
    end
    p_in_valid = 1'b0;

    // Random traffic, checked by the monitor.
    repeat (300) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      step();
    end
    drive(1'b0, 4'h0, 2'b00, 1'b1);
    repeat (4) step();
    check("final empty", 32'(out_valid), 32'd0);
    check("final queue", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imm_extend_buffer.md
IMM_EXTEND_BUFFER -- requirements
Module: imm_extend_buffer

Interface
REQ-001 SHALL have parameter IN_W, default 4: width of the raw immediate field.
REQ-002 SHALL have parameter OUT_W, default 16: datapath width of the extended immediate.
REQ-003 SHALL have parameter SHIFT, default 1: left-shift amount applied in branch-offset mode.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge active.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: the producer presents an immediate.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept an immediate this cycle.
REQ-008 SHALL have port imm_in, input, IN_W bits: raw immediate field.
REQ-009 SHALL have port mode, input, 2 bits: extension mode, sampled together with imm_in.
REQ-010 SHALL have port out_valid, output, 1 bit: imm_out holds a valid result.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts imm_out this cycle.
REQ-012 SHALL have port imm_out, output, OUT_W bits: extended immediate.

Function
REQ-013 SHALL fail elaboration unless IN_W >= 1 and OUT_W >= IN_W + SHIFT.
REQ-014 SHALL, for mode 00 (zero-extend), produce imm_in in the low IN_W bits with all upper bits 0.
REQ-015 SHALL, for mode 01 (sign-extend), replicate imm_in[IN_W-1] into bits OUT_W-1 down to IN_W.
REQ-016 SHALL, for mode 10 (branch offset), sign-extend as in REQ-014/REQ-015 mode 01, then shift left by SHIFT with zero fill, discarding bits shifted out above OUT_W-1.
REQ-017 SHALL, for mode 11 (upper immediate), place imm_in in bits OUT_W-1 down to OUT_W-IN_W and set all lower bits to 0.
REQ-018 SHALL compute the extension combinationally at input and store the result, not the raw field, in a 2-entry FIFO (skid buffer).
REQ-019 SHALL accept (push) an immediate on a rising edge where in_valid=1 and in_ready=1.
REQ-020 SHALL derive in_ready from registered occupancy only: in_ready = 1 when occupancy < 2, with no combinational path from out_ready.
REQ-021 SHALL drive imm_out from the FIFO head register and out_valid = 1 when occupancy >= 1.
REQ-022 SHALL pop the head on a rising edge where out_valid=1 and out_ready=1.
REQ-023 SHALL have a latency of 1 cycle: an immediate pushed at edge N appears on imm_out with out_valid=1 after edge N when the FIFO was empty.
REQ-024 SHALL, on a simultaneous push and pop at occupancy 1, keep occupancy at 1 and make the new entry the head.
REQ-025 SHALL not push at occupancy 2 (in_ready=0), even when out_ready=1 in the same cycle; in_ready returns to 1 on the cycle after the pop.
REQ-026 SHALL preserve order: results leave in push order, with no loss or duplication.
REQ-027 SHALL hold imm_out and out_valid stable while out_valid=1 and out_ready=0.
REQ-028 SHALL ignore imm_in and mode when no push occurs.

Reset
REQ-029 SHALL, while rst=1, immediately force occupancy to 0, out_valid=0, in_ready=1 and imm_out=0, independent of clk.
REQ-030 SHALL discard all buffered entries on a reset asserted mid-operation; no stale entry is output after rst deasserts.
REQ-031 SHALL accept a push on the first rising edge after rst deasserts.

Verification
REQ-032 Bench SHALL cover the modes at the defaults: imm_in=4'b1010 gives, after one edge, 16'h000A (mode 00), 16'hFFFA (mode 01), 16'hFFF4 (mode 10) and 16'hA000 (mode 11); imm_in=4'b0111 in mode 01 gives 16'h0007.
REQ-033 Bench SHALL cover backpressure: with out_ready=0, push 3 values on consecutive cycles -> only 2 accepted, in_ready=0 after the second, imm_out holds the first value stable.
REQ-034 Bench SHALL cover streaming: in_valid=1 and out_ready=1 continuously for 8 values -> one result per cycle, in order, 1-cycle latency, in_ready stays 1.
REQ-035 Bench SHALL cover full-with-pop: at occupancy 2, out_ready=1 and in_valid=1 -> no push that cycle, occupancy becomes 1, in_ready=1 on the next cycle.
REQ-036 Bench SHALL cover mid-operation reset: with occupancy 2, assert rst between edges -> out_valid=0, imm_out=0 and in_ready=1 immediately; after deassert, a single push of 4'b1111 in mode 01 yields 16'hFFFF as the only output.
REQ-037 Bench SHALL cover parameters: IN_W=6, OUT_W=16, SHIFT=2, imm_in=6'b100000 in mode 10 -> 16'hFF80.
